// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// next-PC select codes and the special instruction words.
package if_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_t;

  // Next-PC source select, as driven by the branch/jump control logic
  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_t;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage : if_pkg

// File: rtl/if_instr_mem.sv
// Instruction memory: one synchronous write port used by the debug loader
// and one asynchronous read port feeding the fetch stage.
module if_instr_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Debug write port
  // NOTE: the array has no reset on purpose; a reset must not wipe the loaded
  // program, and a resettable array would not map onto RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule : if_instr_mem

// File: rtl/if_fetch_unit.sv
// MIPS instruction fetch stage: PC register, next-PC mux, LOAD/RUN/HALT FSM
// and the debug-loadable instruction memory. Produces instruction, PC+4 and
// PC+8 for the IF/ID register.
// Optional build macro IF_FETCH_COUNT_EN adds o_fetch_count, a saturating
// count of PC advances.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                   BITS_SIZE = 32,
  parameter int                   ADDR_BITS = 8,
  parameter logic [BITS_SIZE-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_pc_write,
  input  logic [1:0]           i_pc_src,
  input  logic [BITS_SIZE-1:0] i_branch_addr,
  input  logic [BITS_SIZE-1:0] i_jump_addr,
  input  logic [BITS_SIZE-1:0] i_jr_addr,
  input  logic                 i_mem_wr_en,
  input  logic [ADDR_BITS-1:0] i_mem_wr_addr,
  input  logic [BITS_SIZE-1:0] i_mem_wr_data,
  input  logic                 i_load_done,
  output logic [BITS_SIZE-1:0] o_pc,
  output logic [BITS_SIZE-1:0] o_pc4,
  output logic [BITS_SIZE-1:0] o_pc8,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_halt,
  output logic                 o_running
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [BITS_SIZE-1:0] o_fetch_count
`endif
);

  fetch_state_t         state;
  logic [BITS_SIZE-1:0] pc;
  logic [BITS_SIZE-1:0] pc_next;
  logic [BITS_SIZE-1:0] fetch_word;
  logic                 halt_hit;
  logic                 pc_advance;
  logic                 mem_wr_en;

  // Only the loader may write, and only before the program starts
  assign mem_wr_en = (state == ST_LOAD) && i_mem_wr_en;

  if_instr_mem #(
    .DATA_W (BITS_SIZE),
    .ADDR_W (ADDR_BITS)
  ) u_instr_mem (
    .i_clk     (i_clk),
    .i_wr_en   (mem_wr_en),
    .i_wr_addr (i_mem_wr_addr),
    .i_wr_data (i_mem_wr_data),
    .i_rd_addr (pc[ADDR_BITS+1:2]),
    .o_rd_data (fetch_word)
  );

  assign o_pc  = pc;
  assign o_pc4 = pc + BITS_SIZE'(4);
  assign o_pc8 = pc + BITS_SIZE'(8);

  // Outside RUN a NOP goes to IF/ID so the next stage sees a bubble
  assign o_instruction = o_running ? fetch_word : NOP_WORD;

  assign halt_hit   = (state == ST_RUN) && (fetch_word == HALT_WORD);
  // A stall (i_pc_write=0) wins over any redirect; the HALT word never advances
  assign pc_advance = (state == ST_RUN) && i_step && i_pc_write && !halt_hit;

  // Next-PC select; targets are used verbatim, without alignment
  // NOTE: pc_next gets a default first so no path through the block can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_next = o_pc4;
    case (pc_src_t'(i_pc_src))
      PC_SRC_SEQ:    pc_next = o_pc4;
      PC_SRC_BRANCH: pc_next = i_branch_addr;
      PC_SRC_JUMP:   pc_next = i_jump_addr;
      PC_SRC_JR:     pc_next = i_jr_addr;
      default:       pc_next = o_pc4;
    endcase
  end

  // PC register: moves only on an enabled, unstalled RUN cycle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc <= '0;
    end else if (pc_advance) begin
      pc <= pc_next;
    end
  end

  // Fetch FSM with registered running/halt flags
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_LOAD;
      o_running <= 1'b0;
      o_halt    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (i_load_done) begin
            state     <= ST_RUN;
            o_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_step && halt_hit) begin
            state     <= ST_HALT;
            o_running <= 1'b0;
            o_halt    <= 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state     <= ST_LOAD;
          o_running <= 1'b0;
          o_halt    <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_COUNT_EN
  // Saturating count of PC advances; cannot move in HALT since PC is frozen
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_fetch_count <= '0;
    end else if (pc_advance && (o_fetch_count != '1)) begin
      o_fetch_count <= o_fetch_count + BITS_SIZE'(1);
    end
  end
`endif

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: a behavioural model of the fetch stage is
// compared against the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations.
module tb_if_fetch_unit;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        i_clk;
  logic        i_reset;
  logic        i_step;
  logic        i_pc_write;
  logic [1:0]  i_pc_src;
  logic [31:0] i_branch_addr;
  logic [31:0] i_jump_addr;
  logic [31:0] i_jr_addr;
  logic        i_mem_wr_en;
  logic [7:0]  i_mem_wr_addr;
  logic [31:0] i_mem_wr_data;
  logic        i_load_done;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] o_pc8;
  logic [31:0] o_instruction;
  logic        o_halt;
  logic        o_running;
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] o_fetch_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_unit dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_step        (i_step),
    .i_pc_write    (i_pc_write),
    .i_pc_src      (i_pc_src),
    .i_branch_addr (i_branch_addr),
    .i_jump_addr   (i_jump_addr),
    .i_jr_addr     (i_jr_addr),
    .i_mem_wr_en   (i_mem_wr_en),
    .i_mem_wr_addr (i_mem_wr_addr),
    .i_mem_wr_data (i_mem_wr_data),
    .i_load_done   (i_load_done),
    .o_pc          (o_pc),
    .o_pc4         (o_pc4),
    .o_pc8         (o_pc8),
    .o_instruction (o_instruction),
    .o_halt        (o_halt),
    .o_running     (o_running)
`ifdef IF_FETCH_COUNT_EN
    ,
    .o_fetch_count (o_fetch_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: a program image, a PC and two mode flags
  // ---------------------------------------------------------------------
  logic [31:0] m_mem [256];
  logic [31:0] m_pc      = 32'h0;
  bit          m_running = 1'b0;
  bit          m_halted  = 1'b0;
  longint      m_count   = 0;

  always @(posedge i_clk or negedge i_reset) begin
    logic [31:0] word;
    if (!i_reset) begin
      m_pc      = 32'h0;
      m_running = 1'b0;
      m_halted  = 1'b0;
      m_count   = 0;
    end else begin
      word = m_mem[m_pc[9:2]];
      if (!m_running && !m_halted) begin
        if (i_mem_wr_en) m_mem[i_mem_wr_addr] = i_mem_wr_data;
        if (i_load_done) m_running = 1'b1;
      end else if (m_running && i_step) begin
        if (word == HALT_W) begin
          m_running = 1'b0;
          m_halted  = 1'b1;
        end else if (i_pc_write) begin
          if      (i_pc_src == 2'd1) m_pc = i_branch_addr;
          else if (i_pc_src == 2'd2) m_pc = i_jump_addr;
          else if (i_pc_src == 2'd3) m_pc = i_jr_addr;
          else                       m_pc = m_pc + 32'd4;
          if (m_count < 64'hFFFF_FFFF) m_count++;
        end
      end
    end
  end

  // Compare process: every falling edge, outputs against the model
  always @(negedge i_clk) begin
    check("pc",      o_pc,          m_pc);
    check("pc4",     o_pc4,         m_pc + 32'd4);
    check("pc8",     o_pc8,         m_pc + 32'd8);
    check("instr",   o_instruction, m_running ? m_mem[m_pc[9:2]] : 32'h0);
    check("running", {31'b0, o_running}, {31'b0, m_running});
    check("halt",    {31'b0, o_halt},    {31'b0, m_halted});
`ifdef IF_FETCH_COUNT_EN
    check("fetch_count", o_fetch_count, 32'(m_count));
`endif
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mem_write(input logic [7:0] addr, input logic [31:0] data);
    i_mem_wr_en   = 1'b1;
    i_mem_wr_addr = addr;
    i_mem_wr_data = data;
    tick();
    i_mem_wr_en   = 1'b0;
  endtask

  task automatic load_done();
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
  endtask

  initial begin
    i_reset       = 1'b0;
    i_step        = 1'b0;
    i_pc_write    = 1'b1;
    i_pc_src      = 2'd0;
    i_branch_addr = 32'h0;
    i_jump_addr   = 32'h0;
    i_jr_addr     = 32'h0;
    i_mem_wr_en   = 1'b0;
    i_mem_wr_addr = 8'h0;
    i_mem_wr_data = 32'h0;
    i_load_done   = 1'b0;
    #1;
    check("rst_pc4",   o_pc4, 32'h4);
    check("rst_pc8",   o_pc8, 32'h8);
    check("rst_instr", o_instruction, 32'h0);
    tick();
    tick();
    i_reset = 1'b1;

    // Fill the whole image with non-HALT words, then place the program
    for (int i = 0; i < 256; i++) mem_write(8'(i), 32'h1000_0000 + 32'(i));
    mem_write(8'd0, 32'h2001_0005);
    mem_write(8'd1, 32'h2002_0003);

    // Load then run: last write lands on the same edge as load_done
    i_mem_wr_en   = 1'b1;
    i_mem_wr_addr = 8'd3;
    i_mem_wr_data = 32'h2003_0007;
    i_load_done   = 1'b1;
    tick();
    i_mem_wr_en   = 1'b0;
    i_load_done   = 1'b0;
    check("s2_running", {31'b0, o_running}, 32'h1);
    check("s2_instr0",  o_instruction, 32'h2001_0005);
    i_step = 1'b1;
    tick();
    check("s2_pc",     o_pc, 32'h4);
    check("s2_instr1", o_instruction, 32'h2002_0003);

    // Stall vs redirect; a RUN-time write to word 1 must be ignored
    i_pc_src      = 2'd1;
    i_branch_addr = 32'h40;
    i_pc_write    = 1'b0;
    i_mem_wr_en   = 1'b1;
    i_mem_wr_addr = 8'd1;
    i_mem_wr_data = 32'hDEAD_BEEF;
    tick();
    tick();
    i_mem_wr_en = 1'b0;
    check("s3_stall_pc", o_pc, 32'h4);
    i_pc_write = 1'b1;
    tick();
    check("s3_branch_pc", o_pc, 32'h40);
    i_pc_src = 2'd0;

    // Step gating, then JR and word-index wrap
    i_step      = 1'b0;
    i_pc_src    = 2'd2;
    i_jump_addr = 32'h80;
    repeat (3) tick();
    check("s4_frozen_pc", o_pc, 32'h40);
    i_step    = 1'b1;
    i_pc_src  = 2'd3;
    i_jr_addr = 32'h3FC;
    tick();
    check("s4_jr_pc",    o_pc, 32'h3FC);
    check("s4_jr_instr", o_instruction, 32'h1000_00FF);
    i_pc_src = 2'd0;
    tick();
    check("s4_wrap_pc",    o_pc, 32'h400);
    check("s4_wrap_instr", o_instruction, 32'h2001_0005);

    // Jump to the word written alongside load_done
    i_pc_src    = 2'd2;
    i_jump_addr = 32'h0C;
    tick();
    check("s4_jump_instr", o_instruction, 32'h2003_0007);
    // PC+4 / PC+8 wrap modulo 2^32
    i_jump_addr = 32'hFFFF_FFFC;
    tick();
    check("s4_pc4_wrap", o_pc4, 32'h0);
    check("s4_pc8_wrap", o_pc8, 32'h4);
    // Unaligned target is taken verbatim, low bits ignored for the read
    i_pc_src  = 2'd3;
    i_jr_addr = 32'h42;
    tick();
    check("s4_unaligned_pc",    o_pc, 32'h42);
    check("s4_unaligned_instr", o_instruction, 32'h1000_0010);
    i_pc_src = 2'd0;

    // Reset mid-RUN takes effect immediately
    i_reset = 1'b0;
    #1;
    check("s1_pc",      o_pc, 32'h0);
    check("s1_instr",   o_instruction, 32'h0);
    check("s1_running", {31'b0, o_running}, 32'h0);
    tick();
    i_reset = 1'b1;
    i_step  = 1'b0;

    // Halt: HALT word at word 2, run from 0 (words 0/1 retained through reset)
    mem_write(8'd2, HALT_W);
    load_done();
    check("s5_retained", o_instruction, 32'h2001_0005);
    i_step = 1'b1;
    tick();
    i_pc_write = 1'b0;
    tick();
    i_pc_write = 1'b1;
    tick();
    check("s5_pc8",   o_pc, 32'h8);
    check("s5_instr", o_instruction, HALT_W);
    tick();
    check("s5_halt",      {31'b0, o_halt}, 32'h1);
    check("s5_halt_pc",   o_pc, 32'h8);
    check("s5_halt_nop",  o_instruction, 32'h0);
`ifdef IF_FETCH_COUNT_EN
    check("s6_count", o_fetch_count, 32'd2);
`endif
    repeat (2) tick();
    check("s5_sticky_pc", o_pc, 32'h8);
    // Debug write in HALT is ignored: word 2 must still halt after a rerun
    mem_write(8'd2, 32'h1234_5678);
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    load_done();
    repeat (3) tick();
    check("s5_rerun_halt", {31'b0, o_halt}, 32'h1);
    check("s5_rerun_pc",   o_pc, 32'h8);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_if_fetch_unit
